timer_irq: RTL

- Memory-mapped programmable countdown timer: the interrupt source directly upstream of the coprocessor-0 interrupt logic.
- CPU programs it through a word-addressed register port.
- Its `irq` output drives HWint[2] of CP0.
- Supports one-shot (level interrupt held until software acknowledge) and auto-reload (single-cycle interrupt pulse, periodic) modes.

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_irq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer_irq countdown timer.
// Holds the FSM state encoding, register word offsets, CTRL bit positions
// and mode constants used by the timer and by software-facing code.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  // Word offsets selected by byte address bits [3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // CTRL register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Only the exact auto-reload encoding reloads; 1x behaves as one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped programmable countdown timer feeding CP0 HWint[2].
// Software programs PRESET, then sets CTRL.en; the timer loads PRESET into
// COUNT, counts down to 1 and raises an interrupt. One-shot mode holds the
// interrupt until any CTRL write acknowledges it; auto-reload mode emits a
// single-cycle pulse and restarts.
//
// Ports:
//   clk     - system clock, all state on the rising edge
//   reset_n - asynchronous active-low reset
//   addr    - word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   we      - write strobe
//   wdata   - write data
//   rdata   - combinational read of the register selected by addr
//   irq     - interrupt request (irq_pend masked by CTRL.im)
module timer_irq
  import timer_pkg::*;
#(
  parameter int         CNT_W      = 32,
  parameter logic [1:0] RESET_MODE = MODE_ONESHOT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t             state;
  logic               en;
  logic [1:0]         mode;
  logic               im;
  logic               irq_pend;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;

  logic ctrl_wr;
  logic preset_wr;
  logic set_pend;
  logic unused_wdata;

  assign ctrl_wr   = we && (addr == REG_CTRL);
  assign preset_wr = we && (addr == REG_PRESET);

  // The terminal count is 1, but a PRESET of 0 also terminates here so the
  // counter never wraps.
  assign set_pend  = (state == CNT) && en && (count <= CNT_W'(1));

  // Upper write-data bits beyond the stored fields are intentionally dropped.
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      preset <= '0;
    end else if (preset_wr) begin
      preset <= wdata[CNT_W-1:0];
    end
  end

  // FSM, COUNT and CTRL share one block: the bus write to CTRL is placed
  // after the FSM so it overrides the FSM's en-clear on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      en    <= 1'b0;
      mode  <= RESET_MODE;
      im    <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            count <= '0;
            state <= INT;
          end
        end
        INT: begin
          state <= IDLE;
          if (!is_reload(mode)) en <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (ctrl_wr) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        im   <= wdata[CTRL_IM];
      end
    end
  end

  // A new event takes priority over an acknowledge so no interrupt is lost;
  // auto-reload drops the pending flag when leaving INT to form a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= 1'b0;
    end else if (set_pend) begin
      irq_pend <= 1'b1;
    end else if (ctrl_wr || ((state == INT) && is_reload(mode))) begin
      irq_pend <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:   rdata[3:0]       = {im, mode, en};
      REG_PRESET: rdata[CNT_W-1:0] = preset;
      REG_COUNT:  rdata[CNT_W-1:0] = count;
      default:    rdata            = '0;
    endcase
  end

  assign irq = irq_pend & im;

endmodule
